// File: rtl/enemy_wave_control.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_wave_control
//  Description : NUM_ENEMIES independent enemy controllers (spawn delay,
//                position-update handshake, tiered health, despawn) sharing
//                one seconds prescaler and one 16-bit LFSR that supplies
//                random respawn delays.
//                Optional feature macro: ENEMY_KILL_PULSE_EN adds kill_pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_wave_control #(
    parameter int          NUM_ENEMIES   = 4,
    parameter int          HEALTH_W      = 3,
    parameter int          SCORE_W       = 8,
    parameter int          TICKS_PER_SEC = 25000000,
    parameter int          MAX_DELAY_SEC = 4,
    parameter int          TIER1_SCORE   = 10,
    parameter int          TIER2_SCORE   = 30,
    parameter int          HEALTH_T0     = 1,
    parameter int          HEALTH_T1     = 2,
    parameter int          HEALTH_T2     = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [SCORE_W-1:0]              score,
    input  logic [NUM_ENEMIES-1:0]          update_pos,
    input  logic [NUM_ENEMIES-1:0]          bottom_reached,
    input  logic [NUM_ENEMIES-1:0]          hit_bullet,
    input  logic [NUM_ENEMIES-1:0]          hit_player,
    output logic [NUM_ENEMIES-1:0]          in_spawn_wait,
    output logic [NUM_ENEMIES-1:0]          in_update,
    output logic [NUM_ENEMIES-1:0]          active,
    output logic [NUM_ENEMIES*HEALTH_W-1:0] curr_health,
    output logic [NUM_ENEMIES*HEALTH_W-1:0] max_health
`ifdef ENEMY_KILL_PULSE_EN
    ,
    output logic [NUM_ENEMIES-1:0]          kill_pulse
`endif
);

    localparam int c_PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int c_K  = $clog2(MAX_DELAY_SEC);
    localparam int c_DW = c_K + 1;

    localparam logic [c_PW-1:0]     c_TICK_LAST = c_PW'(TICKS_PER_SEC - 1);
    localparam logic [SCORE_W-1:0]  c_TIER1     = SCORE_W'(TIER1_SCORE);
    localparam logic [SCORE_W-1:0]  c_TIER2     = SCORE_W'(TIER2_SCORE);
    localparam logic [HEALTH_W-1:0] c_H0        = HEALTH_W'(HEALTH_T0);
    localparam logic [HEALTH_W-1:0] c_H1        = HEALTH_W'(HEALTH_T1);
    localparam logic [HEALTH_W-1:0] c_H2        = HEALTH_W'(HEALTH_T2);

    typedef enum logic [1:0] {
        S_SPAWN_WAIT = 2'd0,
        S_UPDATE     = 2'd1,
        S_WAIT       = 2'd2,
        S_GEN_DELAY  = 2'd3
    } state_t;

    logic [c_PW-1:0]     r_presc;
    logic                w_sec_tick;
    logic [15:0]         r_lfsr;
    logic                w_lfsr_fb;
    logic [HEALTH_W-1:0] w_tier_h;

    assign w_sec_tick = (r_presc == c_TICK_LAST);
    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Seconds prescaler: wraps after the tick cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (enable) begin
            r_presc <= w_sec_tick ? '0 : r_presc + c_PW'(1);
        end
    end

    // Shared Fibonacci LFSR (taps 16,14,13,11), advances every enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (enable) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Spawn health tier selected from the current score.
    always_comb begin
        w_tier_h = c_H0;
        if (score > c_TIER2) begin
            w_tier_h = c_H2;
        end else if (score >= c_TIER1) begin
            w_tier_h = c_H1;
        end
    end

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_ch
        state_t              r_state, w_state_nxt;
        logic [c_DW-1:0]     r_delay, w_delay_nxt;
        logic [HEALTH_W-1:0] r_health, w_health_nxt;
        logic [HEALTH_W-1:0] r_max, w_max_nxt;
        logic [c_K-1:0]      w_rnd;
        logic                w_dmg;

        // Each channel draws its delay from a different LFSR window.
        for (genvar j = 0; j < c_K; j++) begin : g_rnd
            assign w_rnd[j] = r_lfsr[(i + j) % 16];
        end

        // A bullet hit only counts while the enemy is on screen and alive.
        assign w_dmg = ((r_state == S_UPDATE) || (r_state == S_WAIT)) &&
                       update_pos[i] && hit_bullet[i] && (r_health != '0);

        // Channel next-state, delay and health update.
        always_comb begin
            w_state_nxt  = r_state;
            w_delay_nxt  = r_delay;
            w_health_nxt = r_health;
            w_max_nxt    = r_max;
            if (w_dmg) begin
                w_health_nxt = r_health - HEALTH_W'(1);
            end
            case (r_state)
                S_SPAWN_WAIT: begin
                    if (r_delay == '0) begin
                        w_state_nxt  = S_UPDATE;
                        w_health_nxt = w_tier_h;
                        w_max_nxt    = w_tier_h;
                    end else if (w_sec_tick) begin
                        w_delay_nxt = r_delay - c_DW'(1);
                    end
                end
                S_UPDATE: begin
                    // Despawn test uses the pre-edge health value.
                    if (bottom_reached[i] || hit_player[i] || (r_health == '0)) begin
                        w_state_nxt = S_GEN_DELAY;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (update_pos[i]) begin
                        w_state_nxt = S_UPDATE;
                    end
                end
                S_GEN_DELAY: begin
                    w_delay_nxt  = c_DW'(w_rnd) + c_DW'(1);
                    w_health_nxt = '0;
                    w_state_nxt  = S_SPAWN_WAIT;
                end
                default: begin
                    w_state_nxt = S_SPAWN_WAIT;
                end
            endcase
        end

        // Channel state registers, frozen while disabled.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state  <= S_SPAWN_WAIT;
                r_delay  <= c_DW'(1);
                r_health <= '0;
                r_max    <= '0;
            end else if (enable) begin
                r_state  <= w_state_nxt;
                r_delay  <= w_delay_nxt;
                r_health <= w_health_nxt;
                r_max    <= w_max_nxt;
            end
        end

        assign in_spawn_wait[i] = (r_state == S_SPAWN_WAIT);
        assign in_update[i]     = (r_state == S_UPDATE);
        assign active[i]        = (r_state == S_UPDATE) || (r_state == S_WAIT);
        assign curr_health[i*HEALTH_W +: HEALTH_W] = r_health;
        assign max_health[i*HEALTH_W +: HEALTH_W]  = r_max;

`ifdef ENEMY_KILL_PULSE_EN
        logic r_kill;

        // One-cycle pulse when a bullet takes the last health point.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_kill <= 1'b0;
            end else if (enable) begin
                r_kill <= w_dmg && (r_health == HEALTH_W'(1));
            end
        end

        assign kill_pulse[i] = r_kill;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_enemy_wave_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_wave_control
//  Description : Directed self-checking bench for enemy_wave_control with
//                TICKS_PER_SEC=4, NUM_ENEMIES=2, MAX_DELAY_SEC=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_wave_control;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] score;
    logic [1:0] update_pos;
    logic [1:0] bottom_reached;
    logic [1:0] hit_bullet;
    logic [1:0] hit_player;
    logic [1:0] in_spawn_wait;
    logic [1:0] in_update;
    logic [1:0] active;
    logic [5:0] curr_health;
    logic [5:0] max_health;
`ifdef ENEMY_KILL_PULSE_EN
    logic [1:0] kill_pulse;
`endif

    int n_checks = 0;
    int n_errors = 0;

    enemy_wave_control #(
        .NUM_ENEMIES   (2),
        .HEALTH_W      (3),
        .SCORE_W       (8),
        .TICKS_PER_SEC (4),
        .MAX_DELAY_SEC (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .score          (score),
        .update_pos     (update_pos),
        .bottom_reached (bottom_reached),
        .hit_bullet     (hit_bullet),
        .hit_player     (hit_player),
        .in_spawn_wait  (in_spawn_wait),
        .in_update      (in_update),
        .active         (active),
        .curr_health    (curr_health),
        .max_health     (max_health)
`ifdef ENEMY_KILL_PULSE_EN
        ,
        .kill_pulse     (kill_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Force channel 0 through a despawn, then respawn it at the given score.
    task automatic respawn0(input logic [7:0] sc, input logic [2:0] exp_h, input string tag);
        int n;
        bottom_reached[0] = 1'b1;
        update_pos[0]     = 1'b1;
        n = 0;
        while (!in_spawn_wait[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        bottom_reached[0] = 1'b0;
        update_pos[0]     = 1'b0;
        score             = sc;
        n = 0;
        while (!in_update[0] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_spawn"}, in_update[0], 1'b1);
        chk({tag, "_curr"}, curr_health[2:0], exp_h);
        chk({tag, "_max"}, max_health[2:0], exp_h);
    endtask

    initial begin
        int  n;
        bit  saw_min;
        bit  saw_max;
        reset          = 1'b1;
        enable         = 1'b1;
        score          = 8'd0;
        update_pos     = 2'b00;
        bottom_reached = 2'b00;
        hit_bullet     = 2'b00;
        hit_player     = 2'b00;
        saw_min        = 1'b0;
        saw_max        = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_spawn_wait", in_spawn_wait, 2'b11);
        chk("rst_update", in_update, 2'b00);
        chk("rst_active", active, 2'b00);
        chk("rst_curr", curr_health, 6'd0);
        chk("rst_max", max_health, 6'd0);

        // First spawn: one second of prescaler then one cycle to leave spawn wait.
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("spawn_early", in_update, 2'b00);
        @(negedge clk);
        chk("spawn_on_time", in_update, 2'b11);
        chk("spawn_curr_t0", curr_health, {3'd1, 3'd1});
        chk("spawn_max_t0", max_health, {3'd1, 3'd1});
        @(negedge clk);
        chk("wait_active", active, 2'b11);
        chk("wait_not_update", in_update, 2'b00);

        // Health tiers, including both boundaries.
        respawn0(8'd15, 3'd2, "tier_s15");
        respawn0(8'd9,  3'd1, "tier_s9");
        respawn0(8'd10, 3'd2, "tier_s10");
        respawn0(8'd30, 3'd2, "tier_s30");
        respawn0(8'd31, 3'd3, "tier_s31");

        // Bullet damage from health 3 down to 0, then despawn.
        update_pos[0] = 1'b1;
        hit_bullet[0] = 1'b1;
        @(negedge clk);
        chk("dmg_h2", curr_health[2:0], 3'd2);
        chk("dmg_h2_wait", in_update[0], 1'b0);
`ifdef ENEMY_KILL_PULSE_EN
        chk("kill_h2", kill_pulse[0], 1'b0);
`endif
        @(negedge clk);
        chk("dmg_h1", curr_health[2:0], 3'd1);
        chk("dmg_h1_upd", in_update[0], 1'b1);
        @(negedge clk);
        chk("dmg_h0", curr_health[2:0], 3'd0);
        chk("dmg_h0_active", active[0], 1'b1);
        chk("dmg_max_kept", max_health[2:0], 3'd3);
`ifdef ENEMY_KILL_PULSE_EN
        chk("kill_h0", kill_pulse[0], 1'b1);
`endif
        @(negedge clk);
        chk("dmg_no_underflow", curr_health[2:0], 3'd0);
        chk("dmg_zero_upd", in_update[0], 1'b1);
`ifdef ENEMY_KILL_PULSE_EN
        chk("kill_once", kill_pulse[0], 1'b0);
`endif
        update_pos[0] = 1'b0;
        hit_bullet[0] = 1'b0;
        @(negedge clk);
        chk("dead_gen_delay", {in_spawn_wait[0], active[0]}, 2'b00);
        @(negedge clk);
        chk("dead_spawn_wait", in_spawn_wait[0], 1'b1);

        // Bottom and bullet hit together in S_UPDATE: despawn and decrement.
        respawn0(8'd20, 3'd2, "simul");
        bottom_reached[0] = 1'b1;
        update_pos[0]     = 1'b1;
        hit_bullet[0]     = 1'b1;
        @(negedge clk);
        chk("simul_dec", curr_health[2:0], 3'd1);
        chk("simul_gen_delay", {in_spawn_wait[0], active[0]}, 2'b00);
        hit_bullet[0] = 1'b0;

        // Random respawn delays: 1..4 s gives 2..17 cycles in spawn wait.
        for (int i = 0; i < 100; i++) begin
            n = 0;
            while (!in_spawn_wait[0] && n < 10) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (in_spawn_wait[0] && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("respawn_range", (n >= 2 && n <= 17), 1'b1);
            if (n <= 5)  saw_min = 1'b1;
            if (n >= 14) saw_max = 1'b1;
        end
        chk("respawn_saw_short", saw_min, 1'b1);
        chk("respawn_saw_long", saw_max, 1'b1);
        bottom_reached[0] = 1'b0;
        update_pos[0]     = 1'b0;

        // Channel 1 untouched so far: still waiting with tier-0 health.
        chk("ch1_independent", {active[1], curr_health[5:3]}, {1'b1, 3'd1});

        // Disabled: inputs on channel 1 are ignored.
        enable         = 1'b0;
        update_pos     = 2'b10;
        hit_bullet     = 2'b10;
        bottom_reached = 2'b10;
        repeat (3) @(negedge clk);
        chk("dis_hold_state", {active[1], in_update[1]}, 2'b10);
        chk("dis_hold_health", curr_health[5:3], 3'd1);
        update_pos     = 2'b00;
        hit_bullet     = 2'b00;
        bottom_reached = 2'b00;
        enable         = 1'b1;

        // Asynchronous reset mid-run takes effect without a clock edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_spawn_wait", in_spawn_wait, 2'b11);
        chk("async_active", active, 2'b00);
        chk("async_curr", curr_health, 6'd0);
        chk("async_max", max_health, 6'd0);

        // Twenty disabled cycles delay the first spawn by exactly twenty cycles.
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("frz_spawn_wait", in_spawn_wait, 2'b11);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("frz_spawn_early", in_update, 2'b00);
        @(negedge clk);
        chk("frz_spawn_on_time", in_update, 2'b11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
